// File: rtl/prim_clock_div_pkg.sv
// Shared types and arithmetic for the programmable clock divider: the request FSM
// state encoding and the effective half-period computation.
package prim_clock_div_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StPend = 2'd1,
        StAck  = 2'd2
    } req_state_e;

    localparam int unsigned CalcWidth = 32;

    // Effective half-period: D/2, halved again (never below 1) when step-down is applied.
    function automatic logic [CalcWidth-1:0] half_period(input logic [CalcWidth-1:0] div,
                                                         input logic                 step_down);
        logic [CalcWidth-1:0] h;
        h = div >> 1;
        if (step_down) begin
            h = (h >= CalcWidth'(2)) ? (h >> 1) : CalcWidth'(1);
        end
        return h;
    endfunction

    function automatic logic div_is_valid(input logic [CalcWidth-1:0] div);
        return (div != '0) && !div[0];
    endfunction

endpackage

// File: rtl/prim_clock_buf.sv
// Generic clock buffer cell; a technology library maps this to a dedicated clock buffer.
module prim_clock_buf (
    input  logic clk_i,
    output logic clk_o
);

    assign clk_o = clk_i;

endmodule

// File: rtl/prim_clock_div_prog.sv
// Programmable even-ratio clock divider with a four-phase divisor change handshake
// and a step-down mode; all ratio changes land on the low-to-high period boundary.
module prim_clock_div_prog
    import prim_clock_div_pkg::*;
#(
    parameter int unsigned DivWidth   = 8,
    parameter int unsigned ResetDiv   = 2,
    parameter logic        ResetValue = 1'b0
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                test_en_i,
    input  logic                div_req_i,
    input  logic [DivWidth-1:0] div_i,
    output logic                div_ack_o,
    output logic                div_err_o,
    input  logic                step_down_req_i,
    output logic                step_down_ack_o,
    output logic [DivWidth-1:0] active_div_o,
    output logic                clk_en_o,
    output logic                clk_o
);

    localparam logic [DivWidth-1:0] ResetDivW = DivWidth'(ResetDiv);

    logic [DivWidth-1:0] cnt_q, cnt_d;
    logic [DivWidth-1:0] div_q, div_d;
    logic [DivWidth-1:0] pend_q, pend_d;
    logic                clk_q, clk_d;
    logic                sd_q, sd_d;
    logic                err_q, err_d;
    logic                clk_en_q, clk_en_d;
    req_state_e          state_q, state_d;

    logic [DivWidth-1:0] he;
    logic                he_last;
    logic                boundary;
    logic                div_req_m;
    logic                sd_req_m;

    assign div_req_m = div_req_i & ~test_en_i;
    assign sd_req_m  = step_down_req_i & ~test_en_i;

    assign he       = DivWidth'(half_period(CalcWidth'(div_q), sd_q));
    assign he_last  = (cnt_q == he - 1'b1);
    // Only the end of a low phase may change the ratio, so the next high phase is whole.
    assign boundary = he_last & ~clk_q;

    // NOTE: every signal driven here gets a default first, so no latch is inferred.
    always_comb begin
        cnt_d    = cnt_q + 1'b1;
        clk_d    = clk_q;
        div_d    = div_q;
        pend_d   = pend_q;
        sd_d     = sd_q;
        err_d    = err_q;
        state_d  = state_q;
        clk_en_d = boundary;

        if (he_last) begin
            cnt_d = '0;
            clk_d = ~clk_q;
        end

        if (boundary) begin
            sd_d = sd_req_m;
        end

        unique case (state_q)
            StIdle: begin
                if (div_req_m) begin
                    if (!div_is_valid(CalcWidth'(div_i))) begin
                        state_d = StAck;
                        err_d   = 1'b1;
                    end else begin
                        state_d = StPend;
                        pend_d  = div_i;
                    end
                end
            end
            StPend: begin
                if (boundary) begin
                    state_d = StAck;
                    div_d   = pend_q;
                    err_d   = 1'b0;
                end
            end
            StAck: begin
                if (!div_req_m) begin
                    state_d = StIdle;
                    err_d   = 1'b0;
                end
            end
            default: begin
                state_d = StIdle;
                err_d   = 1'b0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q    <= '0;
            clk_q    <= ResetValue;
            div_q    <= ResetDivW;
            pend_q   <= '0;
            sd_q     <= 1'b0;
            err_q    <= 1'b0;
            clk_en_q <= 1'b0;
            state_q  <= StIdle;
        end else begin
            cnt_q    <= cnt_d;
            clk_q    <= clk_d;
            div_q    <= div_d;
            pend_q   <= pend_d;
            sd_q     <= sd_d;
            err_q    <= err_d;
            clk_en_q <= clk_en_d;
            state_q  <= state_d;
        end
    end

    assign div_ack_o       = (state_q == StAck);
    assign div_err_o       = err_q;
    assign step_down_ack_o = sd_q;
    assign clk_en_o        = clk_en_q;
    assign active_div_o    = {he[DivWidth-2:0], 1'b0};

    prim_clock_buf u_clk_buf (
        .clk_i (clk_q),
        .clk_o (clk_o)
    );

endmodule

// File: doc/prim_clock_div_prog.md
PRIM_CLOCK_DIV_PROG -- requirements
Module: prim_clock_div_prog

Interface
REQ-001 SHALL have parameter DivWidth, default 8, width of the divisor bus.
REQ-002 SHALL have parameter ResetDiv, default 2, divisor applied out of reset; even, 2..2^DivWidth-2.
REQ-003 SHALL have parameter ResetValue, default 1'b0, clk_o level out of reset.
REQ-004 SHALL have one clock and one reset; reset is synchronous, active-low: clk_i  in  1  source clock.
REQ-005 SHALL have rst_ni  in  1  synchronous active-low reset, sampled on clk_i rising edge.
REQ-006 SHALL have test_en_i  in  1  scan/test mode; masks all request inputs.
REQ-007 SHALL have div_req_i  in  1  divisor change request, level, four-phase.
REQ-008 SHALL have div_i  in  DivWidth  requested divisor; stable while div_req_i high.
REQ-009 SHALL have div_ack_o  out  1  request acknowledge, held until div_req_i falls.
REQ-010 SHALL have div_err_o  out  1  request rejected; valid only while div_ack_o high.
REQ-011 SHALL have step_down_req_i  in  1  halve the half-period, level.
REQ-012 SHALL have step_down_ack_o  out  1  step-down currently applied.
REQ-013 SHALL have active_div_o  out  DivWidth  effective divisor now producing clk_o.
REQ-014 SHALL have clk_en_o  out  1  one-cycle pulse, first clk_i cycle of each clk_o high phase.
REQ-015 SHALL have clk_o  out  1  divided clock.

Function
REQ-016 Base half-period H = D/2 where D = applied divisor; effective half-period He = step-down ? max(1, H>>1) : H; active_div_o = 2*He.
REQ-017 Counter cnt counts 0..He-1 per clk_i cycle; on cnt==He-1, cnt<=0 and internal clk_q toggles; clk_o = clk_q via buffer, no combinational path from inputs.
REQ-018 He==1 SHALL toggle clk_q every clk_i cycle (divide-by-2).
REQ-019 clk_en_o SHALL be registered, high exactly in the clk_i cycle where clk_q first reads 1.
REQ-020 Masked requests: div_req and step_down_req internally forced 0 while test_en_i high; an already-PEND request stays pending.
REQ-021 Request FSM states IDLE, PEND, ACK; reset state IDLE.
REQ-022 IDLE -> ACK with div_err_o=1, divisor unchanged, when div_req high and div_i odd or zero (ack 1 cycle after sampling).
REQ-023 IDLE -> PEND when div_req high and div_i valid; div_i captured into pending register.
REQ-024 PEND -> ACK at the period boundary (cnt==He-1 and clk_q==0); new D takes effect for the clk_o high phase starting that edge; div_err_o=0.
REQ-025 ACK -> IDLE when div_req low; div_ack_o, div_err_o deassert same cycle as the transition is registered.
REQ-026 step_down_req changes SHALL apply only at the same period boundary; step_down_ack_o updates in that cycle.
REQ-027 Divisor update and step-down change at the same boundary SHALL both apply; He computed from new D and new step-down.
REQ-028 No clk_o high or low phase SHALL be shorter than min(old He, new He) clk_i cycles (glitch-free).
REQ-029 div_i changes while PEND are ignored (captured value used).

Reset
REQ-030 rst_ni low at a clk_i edge SHALL set cnt=0, clk_q=ResetValue, D=ResetDiv, step-down off, FSM IDLE, div_ack_o=0, div_err_o=0, step_down_ack_o=0, clk_en_o=0, active_div_o=ResetDiv.
REQ-031 Reset mid-PEND SHALL discard the pending divisor; no ack issued.

Structure
REQ-032 Package prim_clock_div_pkg SHALL hold the FSM state enum and the He computation function.
REQ-033 One sub-module: prim_clock_buf instance on clk_o; all other logic in this module.

Verification
REQ-034 Reset, DivWidth=8, ResetDiv=2 -> clk_o period 2 clk_i, active_div_o=2, clk_en_o every 2nd cycle.
REQ-035 div_req with div_i=10 while D=4 -> ack only at boundary with clk_q==0, then period 10 (5 high/5 low), err=0.
REQ-036 div_req with div_i=7, then div_i=0 -> div_ack_o and div_err_o high 1 cycle after req, active_div_o unchanged.
REQ-037 D=12, raise step_down_req -> at next boundary step_down_ack_o=1, active_div_o=6; D=2 with step-down -> active_div_o stays 2.
REQ-038 Request to 8 pending, test_en_i high, rst_ni low mid-PEND -> no ack, active_div_o=ResetDiv, clk_o=ResetValue.
REQ-039 Simultaneous div change 8->16 and step-down at same boundary -> active_div_o=8, no phase shorter than 4 cycles.
